rx_oversample_timer: RTL and testbench
======================================

# rx_oversample_timer

Parametrised oversampling bit/edge timer for the UART receive path. It counts oversampling edges within each bit and bits within a frame, and emits three mid-bit sample strobes for the majority-vote sampler. It also emits per-bit and end-of-frame pulses. Frame format (data length, parity, stop bits) and prescale are run-time configurable and latched per frame, so the RX FSM no longer has to compare counter values itself.

## Interface
- PRESCALE_W, default 6: width of `prescale` and `edge_cnt`. Maximum ratio is 2^PRESCALE_W-1.
- MAX_DATA_BITS, default 8: largest legal `data_bits` value.
- BIT_CNT_W (localparam) = clog2(MAX_DATA_BITS+5): width of `bit_cnt`.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- counter_en  in  1  enable from RX FSM. Low forces IDLE.
- new_start  in  1  one-cycle start-edge detect; begins or resynchronises a frame.
- prescale  in  PRESCALE_W  oversampling ratio; legal range 4..2^PRESCALE_W-1.
- data_bits  in  4  data length; legal range 5..MAX_DATA_BITS.
- par_en  in  1  parity bit present.
- stop2  in  1  two stop bits (else one).
- edge_cnt  out  PRESCALE_W  edge index within the current bit, 0..presc_q-1.
- bit_cnt  out  BIT_CNT_W  bit index in the frame. 0 = start bit.
- sample_stb  out  3  one-hot sample strobes: [0] early, [1] mid, [2] late.
- bit_done  out  1  last edge of the current bit.
- frame_done  out  1  last edge of the last stop bit.
- busy  out  1  state is RUN.
- cfg_err  out  1  one-cycle pulse: `new_start` was seen with illegal configuration.

## Operation
- States: IDLE, RUN, HOLD. Reset enters IDLE.
- Reset values: all counters and latched config are 0; all outputs are 0.
- Event priority each cycle: RST, then `counter_en`=0, then `new_start`, then normal counting.
- `counter_en`=0, any state: next state is IDLE; `edge_cnt`=0 and `bit_cnt`=0. No strobes are asserted while in IDLE or HOLD.
- `new_start`=1 with `counter_en`=1, any state:
  - Legal config: latch `presc_q`, `data_bits`, `par_en`, `stop2`. Go to RUN with `edge_cnt`=1, `bit_cnt`=0. The start cycle itself counts as edge 0.
  - Illegal config (`prescale`<4, or `data_bits`<5, or `data_bits`>MAX_DATA_BITS): assert `cfg_err` next cycle, then go to IDLE with counters cleared.
- Frame length FL = 1 + data_bits_q + par_en_q + 1 + stop2_q.
- RUN, no `new_start`:
  - If `edge_cnt` < presc_q-1: `edge_cnt`+1.
  - If `edge_cnt` = presc_q-1: `edge_cnt` goes to 0 and `bit_cnt`+1.
  - If that wrap happens on `bit_cnt`=FL-1: go to HOLD instead, with both counters at 0.
- HOLD: counters stay at 0 until `new_start` arrives or `counter_en` drops.
- Decodes (only in RUN, combinational from registered state only; no input-to-output path):
  - `bit_done` = (`edge_cnt`==presc_q-1).
  - `frame_done` = `bit_done` && (`bit_cnt`==FL-1).
  - With mid = presc_q>>1: `sample_stb`[0] at `edge_cnt`==mid-1, [1] at mid, [2] at mid+1.
- Input changes to `prescale`, `data_bits`, `par_en` or `stop2` during RUN have no effect until the next `new_start`.
- Counter arithmetic is unsigned, with no overflow: `edge_cnt` ≤ 2^PRESCALE_W-2, and `bit_cnt` ≤ FL-1 < 2^BIT_CNT_W.

## Timing
- `new_start` accepted at cycle t, legal config: RUN from t+1.
- Bit k occupies cycles t+k·P through t+(k+1)·P-1, where P = presc_q.
- `sample_stb`[1] for bit k is high at cycle t+k·P+mid.
- `bit_done` for bit k is high at cycle t+(k+1)·P-1.
- `frame_done` is high at cycle t+FL·P-1. State is HOLD at t+FL·P.
- `new_start` in the same cycle as `frame_done`: `frame_done` still pulses that cycle, and the restart wins (RUN, `edge_cnt`=1 next cycle).
- `new_start` mid-frame: immediate resync; `bit_cnt`=0 and `edge_cnt`=1 next cycle. No `frame_done` is produced for the aborted frame.
- RST asserted mid-frame: all outputs are 0 immediately (asynchronous). First count occurs on the first `new_start` after RST is released.
- `cfg_err` is high for exactly the one cycle after the offending `new_start`. `busy`=0 in that cycle.

## Test plan
- 8N1, prescale=8, `new_start` at t: `sample_stb`[1] at t+4, t+12, …; `bit_done` at t+7; `frame_done` only at t+79; HOLD with counters at 0 from t+80.
- 7 data bits, parity, 2 stop, prescale=16: FL=11; `frame_done` at t+175. Changing `prescale` to 8 at t+30 alters nothing.
- Second `new_start` at t+37 of an 8N1/P=8 frame: `bit_cnt`=0 and `edge_cnt`=1 at t+38; `frame_done` at t+37+79 only.
- Illegal configs, prescale=3 or `data_bits`=4: `cfg_err` pulses once, `busy` stays 0, counters stay 0. Same check at prescale=4 (legal): strobes at edges 1, 2, 3.
- Drop `counter_en` at bit 5, then RST pulse mid-frame: counters are 0 on the next edge (for `counter_en`) and asynchronously (for RST). No stray `bit_done` or `frame_done`. Both with `new_start` and `frame_done` in the same cycle: restart and pulse both occur.

Source files
------------

// File: rtl/rx_oversample_timer.sv
// Oversampling bit/edge timer for the UART receiver: counts edges within a bit and
// bits within a frame, and decodes mid-bit sample strobes, bit_done and frame_done.
module rx_oversample_timer #(
  parameter  int PRESCALE_W    = 6,
  parameter  int MAX_DATA_BITS = 8,
  localparam int BIT_CNT_W     = $clog2(MAX_DATA_BITS + 5)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  counter_en,
  input  logic                  new_start,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_bits,
  input  logic                  par_en,
  input  logic                  stop2,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic [2:0]            sample_stb,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0]            MAX_DB    = 4'(MAX_DATA_BITS);
  localparam logic [PRESCALE_W-1:0] MIN_PRESC = PRESCALE_W'(4);

  state_t                  state_reg, state_next;
  logic [PRESCALE_W-1:0]   edge_reg, edge_next;
  logic [BIT_CNT_W-1:0]    bit_reg, bit_next;
  logic                    cfg_err_reg, cfg_err_next;
  logic                    latch_cfg;

  // Frame configuration captured at each accepted new_start.
  logic [PRESCALE_W-1:0]   presc_q;
  logic [3:0]              data_bits_q;
  logic                    par_q;
  logic                    stop2_q;

  logic                    cfg_legal;
  logic [PRESCALE_W-1:0]   last_edge;
  logic [PRESCALE_W-1:0]   mid;
  logic [BIT_CNT_W-1:0]    last_bit;
  logic                    at_last_edge;
  logic                    at_last_bit;
  logic                    in_run;

  assign cfg_legal = (prescale >= MIN_PRESC) &&
                     (data_bits >= 4'd5) &&
                     (data_bits <= MAX_DB);

  // last_bit = FL-1 = data bits + parity + stop2 + 1 (start and first stop bit).
  assign last_edge    = presc_q - 1'b1;
  assign mid          = presc_q >> 1;
  assign last_bit     = BIT_CNT_W'(data_bits_q) + BIT_CNT_W'(par_q) +
                        BIT_CNT_W'(stop2_q) + BIT_CNT_W'(1);
  assign at_last_edge = (edge_reg == last_edge);
  assign at_last_bit  = (bit_reg == last_bit);
  assign in_run       = (state_reg == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      edge_reg    <= '0;
      bit_reg     <= '0;
      cfg_err_reg <= 1'b0;
      presc_q     <= '0;
      data_bits_q <= '0;
      par_q       <= 1'b0;
      stop2_q     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      edge_reg    <= edge_next;
      bit_reg     <= bit_next;
      cfg_err_reg <= cfg_err_next;
      if (latch_cfg) begin
        presc_q     <= prescale;
        data_bits_q <= data_bits;
        par_q       <= par_en;
        stop2_q     <= stop2;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    edge_next    = edge_reg;
    bit_next     = bit_reg;
    cfg_err_next = 1'b0;
    latch_cfg    = 1'b0;
    if (!counter_en) begin
      state_next = IDLE;
      edge_next  = '0;
      bit_next   = '0;
    end else if (new_start) begin
      bit_next = '0;
      if (cfg_legal) begin
        // The start cycle itself is edge 0, so the first RUN cycle is edge 1.
        state_next = RUN;
        edge_next  = PRESCALE_W'(1);
        latch_cfg  = 1'b1;
      end else begin
        state_next   = IDLE;
        edge_next    = '0;
        cfg_err_next = 1'b1;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (at_last_edge) begin
            edge_next = '0;
            if (at_last_bit) begin
              state_next = HOLD;
              bit_next   = '0;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            edge_next = edge_reg + 1'b1;
          end
        end
        default: begin
          edge_next = '0;
          bit_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    edge_cnt      = edge_reg;
    bit_cnt       = bit_reg;
    busy          = in_run;
    cfg_err       = cfg_err_reg;
    bit_done      = in_run && at_last_edge;
    frame_done    = in_run && at_last_edge && at_last_bit;
    sample_stb    = 3'b000;
    if (in_run) begin
      sample_stb[0] = (edge_reg == mid - 1'b1);
      sample_stb[1] = (edge_reg == mid);
      sample_stb[2] = (edge_reg == mid + 1'b1);
    end
  end

endmodule

// File: tb/tb_rx_oversample_timer.sv
// Bench for rx_oversample_timer: directed vector table, hand-written frame sequences,
// and randomized traffic checked every cycle against an elapsed-time reference model.
module tb_rx_oversample_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       ns;
  logic [5:0] prescale;
  logic [3:0] db;
  logic       par;
  logic       st;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [2:0] sample_stb;
  logic       bit_done;
  logic       frame_done;
  logic       busy;
  logic       cfg_err;

  int n_cmp  = 0;
  int n_fail = 0;

  rx_oversample_timer dut (
    .clk        (clk),
    .rst        (rst),
    .counter_en (ce),
    .new_start  (ns),
    .prescale   (prescale),
    .data_bits  (db),
    .par_en     (par),
    .stop2      (st),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sample_stb (sample_stb),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: a running frame is just "cycles since start" plus its latched P and FL.
  bit m_run;
  bit m_err;
  int m_el;
  int m_p;
  int m_fl;

  function automatic void model_clear();
    m_run = 1'b0;
    m_err = 1'b0;
    m_el  = 0;
  endfunction

  function automatic void model_step();
    bit legal;
    legal = (int'(prescale) >= 4) && (int'(db) >= 5) && (int'(db) <= 8);
    m_err = 1'b0;
    if (!ce) begin
      m_run = 1'b0;
    end else if (ns) begin
      if (legal) begin
        m_run = 1'b1;
        m_el  = 1;
        m_p   = int'(prescale);
        m_fl  = 2 + int'(db) + int'(par) + int'(st);
      end else begin
        m_run = 1'b0;
        m_err = 1'b1;
      end
    end else if (m_run) begin
      m_el++;
      if (m_el == m_fl * m_p) m_run = 1'b0;
    end
  endfunction

  function automatic logic [16:0] model_out();
    int e, b, mid;
    logic [2:0] s;
    if (m_run) begin
      e   = m_el % m_p;
      b   = m_el / m_p;
      mid = m_p / 2;
      s   = {e == mid + 1, e == mid, e == mid - 1};
      return {6'(e), 4'(b), s, e == m_p - 1, m_el == m_fl * m_p - 1, 1'b1, m_err};
    end
    return {13'd0, 1'b0, 1'b0, 1'b0, m_err};
  endfunction

  function automatic logic [16:0] dut_out();
    return {edge_cnt, bit_cnt, sample_stb, bit_done, frame_done, busy, cfg_err};
  endfunction

  task automatic cmp_vec(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got edge=%0d bit=%0d stb=%b bd=%b fd=%b busy=%b err=%b, required edge=%0d bit=%0d stb=%b bd=%b fd=%b busy=%b err=%b",
               name, got[16:11], got[10:7], got[6:4], got[3], got[2], got[1], got[0],
               exp[16:11], exp[10:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    cmp_vec(name, dut_out(), model_out());
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_clear();
    cmp_vec("rst_async", dut_out(), model_out());
    @(posedge clk);
    #1;
    cmp_vec("rst_held", dut_out(), model_out());
    rst = 1'b0;
  endtask

  task automatic start_frame(input int p, input int d, input bit pe, input bit s2);
    ce       = 1'b1;
    ns       = 1'b1;
    prescale = 6'(p);
    db       = 4'(d);
    par      = pe;
    st       = s2;
    tick("start");
    ns = 1'b0;
  endtask

  int fd_hits[$];
  int bd_hits[$];
  int stb1_hits[$];
  int rs_edge;
  int rs_bit;

  // Observes cycles t+1..t+ncyc of a running frame; optional prescale change and restart.
  task automatic observe(input int ncyc, input int chg_at, input int rs_at);
    fd_hits.delete();
    bd_hits.delete();
    stb1_hits.delete();
    rs_edge = -1;
    rs_bit  = -1;
    for (int n = 1; n <= ncyc; n++) begin
      if (frame_done) fd_hits.push_back(n);
      if (bit_done) bd_hits.push_back(n);
      if (sample_stb[1]) stb1_hits.push_back(n);
      if (n == rs_at + 1) begin
        rs_edge = int'(edge_cnt);
        rs_bit  = int'(bit_cnt);
      end
      if (n == chg_at) prescale = 6'd8;
      ns = (n == rs_at);
      tick("observe");
    end
    ns = 1'b0;
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  typedef struct {
    logic       ce;
    logic       ns;
    logic [5:0] presc;
    logic [3:0] db;
    logic       par;
    logic       st;
    logic [5:0] e_edge;
    logic [3:0] e_bit;
    logic [2:0] e_stb;
    logic       e_bd;
    logic       e_fd;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int cnt;

    //              ce    ns    presc  db    par   st    edge   bit   stb     bd    fd    busy  err
    vecs[0]  = '{1'b1, 1'b1, 6'd3,  4'd8, 1'b0, 1'b0, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 6'd3,  4'd8, 1'b0, 1'b0, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 6'd8,  4'd4, 1'b0, 1'b0, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 6'd8,  4'd4, 1'b0, 1'b0, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 6'd8,  4'd9, 1'b0, 1'b0, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 6'd4,  4'd5, 1'b0, 1'b0, 6'd1, 4'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 6'd4,  4'd5, 1'b0, 1'b0, 6'd2, 4'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 6'd4,  4'd5, 1'b0, 1'b0, 6'd3, 4'd0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 6'd4,  4'd5, 1'b0, 1'b0, 6'd0, 4'd1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 6'd2,  4'd5, 1'b0, 1'b0, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 6'd4,  4'd5, 1'b0, 1'b0, 6'd1, 4'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 6'd4,  4'd5, 1'b0, 1'b0, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 6'd63, 4'd8, 1'b1, 1'b1, 6'd1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 6'd63, 4'd8, 1'b1, 1'b1, 6'd2, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};

    rst      = 1'b1;
    ce       = 1'b0;
    ns       = 1'b0;
    prescale = 6'd8;
    db       = 4'd8;
    par      = 1'b0;
    st       = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    cmp_vec("reset", dut_out(), {17'd0});
    rst = 1'b0;
    tick("idle");

    foreach (vecs[i]) begin
      ce       = vecs[i].ce;
      ns       = vecs[i].ns;
      prescale = vecs[i].presc;
      db       = vecs[i].db;
      par      = vecs[i].par;
      st       = vecs[i].st;
      tick("vec_model");
      cmp_vec($sformatf("vec%0d", i), dut_out(),
              {vecs[i].e_edge, vecs[i].e_bit, vecs[i].e_stb, vecs[i].e_bd,
               vecs[i].e_fd, vecs[i].e_busy, vecs[i].e_err});
      $display("vec %0d: ce=%b ns=%b presc=%0d db=%0d -> edge=%0d bit=%0d stb=%b busy=%b err=%b",
               i, ce, ns, prescale, db, edge_cnt, bit_cnt, sample_stb, busy, cfg_err);
    end
    ns = 1'b0;
    ce = 1'b0;
    tick("drop");

    // 8N1, P=8
    start_frame(8, 8, 0, 0);
    observe(90, -1, -1);
    chk("8n1_fd_count", fd_hits.size(), 1);
    chk("8n1_fd_at", qget(fd_hits, 0), 79);
    chk("8n1_bd_first", qget(bd_hits, 0), 7);
    chk("8n1_bd_count", bd_hits.size(), 10);
    chk("8n1_stb1_first", qget(stb1_hits, 0), 4);
    chk("8n1_stb1_second", qget(stb1_hits, 1), 12);
    chk("8n1_hold_edge", int'(edge_cnt), 0);
    chk("8n1_hold_busy", int'(busy), 0);
    $display("seq 8N1 P=8: frame_done at t+%0d", qget(fd_hits, 0));

    // 7 data, parity, 2 stop, P=16 with a prescale change mid-frame
    start_frame(16, 7, 1, 1);
    observe(185, 30, -1);
    chk("7p2_fd_count", fd_hits.size(), 1);
    chk("7p2_fd_at", qget(fd_hits, 0), 175);
    chk("7p2_bd_count", bd_hits.size(), 11);
    chk("7p2_stb1_last", qget(stb1_hits, 10), 168);
    $display("seq 7P2 P=16: frame_done at t+%0d", qget(fd_hits, 0));

    // Resync at t+37
    start_frame(8, 8, 0, 0);
    observe(125, -1, 37);
    chk("resync_fd_count", fd_hits.size(), 1);
    chk("resync_fd_at", qget(fd_hits, 0), 116);
    chk("resync_edge", rs_edge, 1);
    chk("resync_bit", rs_bit, 0);
    $display("seq resync at t+37: frame_done at t+%0d", qget(fd_hits, 0));

    // new_start coincident with frame_done
    start_frame(8, 8, 0, 0);
    observe(170, -1, 79);
    chk("coinc_fd_count", fd_hits.size(), 2);
    chk("coinc_fd_first", qget(fd_hits, 0), 79);
    chk("coinc_fd_second", qget(fd_hits, 1), 158);
    chk("coinc_edge", rs_edge, 1);
    chk("coinc_bit", rs_bit, 0);
    $display("seq restart on frame_done: pulses at t+%0d and t+%0d", qget(fd_hits, 0), qget(fd_hits, 1));

    // counter_en drop at bit 5, then asynchronous reset mid-frame
    start_frame(8, 8, 0, 0);
    repeat (43) tick("run");
    chk("pre_drop_bit", int'(bit_cnt), 5);
    ce = 1'b0;
    tick("ce_drop");
    chk("ce_drop_edge", int'(edge_cnt), 0);
    chk("ce_drop_bit", int'(bit_cnt), 0);
    chk("ce_drop_busy", int'(busy), 0);
    ce = 1'b1;
    tick("ce_back");
    start_frame(8, 8, 0, 0);
    repeat (20) tick("run");
    async_reset();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick("post_rst");
      if (bit_done || frame_done || busy) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);
    start_frame(8, 8, 0, 0);
    chk("post_rst_restart_edge", int'(edge_cnt), 1);
    chk("post_rst_restart_busy", int'(busy), 1);
    $display("seq ce drop + async reset done");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) async_reset();
      ce = ($urandom_range(0, 99) != 0);
      ns = ($urandom_range(0, 149) == 0);
      if (ns || $urandom_range(0, 19) == 0) begin
        prescale = 6'($urandom_range(2, 12));
        db       = 4'($urandom_range(4, 9));
        par      = 1'($urandom_range(0, 1));
        st       = 1'($urandom_range(0, 1));
      end
      tick("random");
    end
    ns = 1'b0;
    $display("random phase: 4000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
